exe_stage: RTL and testbench



---
 rtl/exe_stage.sv | 166 ++++++++++++++++
 tb/tb_exe_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage: RV64 execute-stage front end.
// Latches decoded instructions into an operand register (S1), drives the
// external combinational ALU with *W-conditioned operands, and registers the
// conditioned ALU result into the output register (S2) toward memory.
// Optional feature: define EXE_BYPASS_EN to forward in-flight results into
// the source operands at S1 capture.
// ALU select codes follow the existing ALU encoding:
//   ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
module exe_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_alusel,
  input  logic            in_asel,
  input  logic            in_bsel,
  input  logic            in_word,
  input  logic            in_wen,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen
);

  localparam int unsigned SELW = 4;
  localparam int unsigned REGW = 5;
  localparam logic [SELW-1:0] SEL_SLL = SELW'(2);
  localparam logic [SELW-1:0] SEL_SRL = SELW'(6);
  localparam logic [SELW-1:0] SEL_SRA = SELW'(7);

  // S1 operand register
  logic            s1_valid;
  logic [XLEN-1:0] s1_x;
  logic [XLEN-1:0] s1_y;
  logic [SELW-1:0] s1_sel;
  logic            s1_word;
  logic [REGW-1:0] s1_rd;
  logic            s1_wen;

  logic            s2_adv;
  logic            in_fire;
  logic [XLEN-1:0] s1_result;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            is_shift;

  // Handshake: S2 moves when empty or drained; S1 follows S2.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    in_ready = !s1_valid || s2_adv;
    in_fire  = in_valid && in_ready;
  end

  // *W operand conditioning toward the ALU and result conditioning from it.
  always_comb begin
    is_shift = (s1_sel == SEL_SLL) || (s1_sel == SEL_SRL) || (s1_sel == SEL_SRA);
    alu_sel  = s1_sel;
    alu_x    = s1_x;
    alu_y    = s1_y;
    if (s1_word) begin
      if (s1_sel == SEL_SRL) begin
        alu_x = XLEN'(s1_x[31:0]);
      end else begin
        alu_x = {{(XLEN-32){s1_x[31]}}, s1_x[31:0]};
      end
      if (is_shift) begin
        alu_y = XLEN'(s1_y[4:0]);
      end
    end
    s1_result = s1_word ? {{(XLEN-32){alu_z[31]}}, alu_z[31:0]} : alu_z;
  end

`ifdef EXE_BYPASS_EN
  // Forward the youngest in-flight writer of each source (S1 first, then S2).
  always_comb begin
    rs1_val = in_rs1_val;
    rs2_val = in_rs2_val;
    if (in_rs1_idx != REGW'(0)) begin
      if (s1_valid && s2_adv && s1_wen && (s1_rd == in_rs1_idx)) begin
        rs1_val = s1_result;
      end else if (out_valid && out_wen && (out_rd == in_rs1_idx)) begin
        rs1_val = out_result;
      end
    end
    if (in_rs2_idx != REGW'(0)) begin
      if (s1_valid && s2_adv && s1_wen && (s1_rd == in_rs2_idx)) begin
        rs2_val = s1_result;
      end else if (out_valid && out_wen && (out_rd == in_rs2_idx)) begin
        rs2_val = out_result;
      end
    end
  end
`else
  // Hazards are resolved upstream; source indices are not needed here.
  logic unused_idx;
  always_comb begin
    rs1_val    = in_rs1_val;
    rs2_val    = in_rs2_val;
    unused_idx = ^{in_rs1_idx, in_rs2_idx};
  end
`endif

  // S1: capture selected operands on handshake; flush kills the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_sel   <= '0;
      s1_word  <= 1'b0;
      s1_rd    <= '0;
      s1_wen   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_fire) begin
        s1_valid <= 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (in_fire && !flush) begin
        s1_x    <= in_asel ? in_pc : rs1_val;
        s1_y    <= in_bsel ? in_imm : rs2_val;
        s1_sel  <= in_alusel;
        s1_word <= in_word;
        s1_rd   <= in_rd;
        s1_wen  <= in_wen;
      end
    end
  end

  // S2: register the conditioned result; writes to x0 never enable writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wen    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s1_result;
        out_rd     <= s1_rd;
        out_wen    <= s1_wen && (s1_rd != REGW'(0));
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against an
// instruction-level reference model; a stand-in 64-bit ALU closes the loop.
module tb_exe_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
  logic [3:0]  in_alusel;
  logic        in_asel, in_bsel, in_word, in_wen;
  logic [63:0] alu_x, alu_y, alu_z;
  logic [3:0]  alu_sel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;

  int n_tests = 0;
  int n_fail  = 0;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd(in_rd),
    .in_alusel(in_alusel), .in_asel(in_asel), .in_bsel(in_bsel),
    .in_word(in_word), .in_wen(in_wen),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen)
  );

  always #5 clk = ~clk;

  // ISA semantics of one instruction from its architectural operands.
  function automatic logic [63:0] sem(input logic [3:0] sel, input logic [63:0] a,
                                      input logic [63:0] b, input logic w);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r   = '0;
    if (w) begin
      case (sel)
        ADD:     r32 = a32 + b32;
        SUB:     r32 = a32 - b32;
        SLL:     r32 = a32 << b32[4:0];
        SRL:     r32 = a32 >> b32[4:0];
        SRA:     r32 = 32'($signed(a32) >>> b32[4:0]);
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (sel)
        ADD:     r = a + b;
        SUB:     r = a - b;
        SLL:     r = a << b[5:0];
        SLT:     r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        SLTU:    r = (a < b) ? 64'd1 : 64'd0;
        XOR:     r = a ^ b;
        SRL:     r = a >> b[5:0];
        SRA:     r = 64'($signed(a) >>> b[5:0]);
        OR:      r = a | b;
        AND:     r = a & b;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Stand-in for the existing 64-bit ALU.
  always_comb alu_z = sem(alu_sel, alu_x, alu_y, 1'b0);

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  // Model: the older in-flight instruction (at the output) and the younger one.
  ent_t m1, m2;
  logic m1v = 1'b0, m2v = 1'b0;
  logic [63:0] drained[$];

  function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] val);
`ifdef EXE_BYPASS_EN
    if (idx != 5'd0 && m1v && m1.wen && m1.rd == idx) return m1.res;
    if (idx != 5'd0 && m2v && m2.wen && m2.rd == idx) return m2.res;
`endif
    if (idx == 5'd31) return val;
    return val;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check in_ready, advance the model, then check outputs.
  task automatic cycle();
    logic rdy_exp, s2adv, acc;
    logic [63:0] a, b;
    ent_t ne;
    #1;
    rdy_exp = !m1v || !m2v || out_ready;
    check("in_ready", 64'(in_ready), 64'(rdy_exp));
    if (out_valid && out_ready) drained.push_back(out_result);
    ne = '0;
    if (flush) begin
      m1v = 1'b0;
      m2v = 1'b0;
    end else begin
      s2adv = !m2v || out_ready;
      acc   = in_valid && rdy_exp;
      if (acc) begin
        a      = in_asel ? in_pc : fwd(in_rs1_idx, in_rs1_val);
        b      = in_bsel ? in_imm : fwd(in_rs2_idx, in_rs2_val);
        ne.res = sem(in_alusel, a, b, in_word);
        ne.rd  = in_rd;
        ne.wen = in_wen;
      end
      if (s2adv) begin
        if (m1v) m2 = m1;
        m2v = m1v;
      end
      if (acc) begin
        m1  = ne;
        m1v = 1'b1;
      end else if (s2adv) begin
        m1v = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m2v));
    if (m2v) begin
      check("out_result", out_result, m2.res);
      check("out_rd", 64'(out_rd), 64'(m2.rd));
      check("out_wen", 64'(out_wen), 64'(m2.wen && m2.rd != 5'd0));
    end
  endtask

  task automatic issue(input logic [3:0] sel, input logic w, input logic bsel,
                       input logic [63:0] r1, input logic [4:0] i1, input logic [63:0] r2,
                       input logic [63:0] imm, input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; in_alusel = sel; in_word = w; in_bsel = bsel; in_asel = 1'b0;
    in_pc = '0; in_rs1_val = r1; in_rs1_idx = i1; in_rs2_val = r2; in_rs2_idx = 5'd0;
    in_imm = imm; in_rd = rd; in_wen = wen;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [63:0] bypass_exp;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    issue(ADD, 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst alu_x", alu_x, 64'd0);
    check("rst alu_y", alu_y, 64'd0);
    check("rst alu_sel", 64'(alu_sel), 64'd0);
    check("rst out_result", out_result, 64'd0);
    check("rst out_wen", 64'(out_wen), 64'd0);
    rst_n = 1'b1;

    // ADD rs1=5, imm=-7
    issue(ADD, 1'b0, 1'b1, 64'd5, 5'd0, '0, 64'hFFFF_FFFF_FFFF_FFF9, 5'd3, 1'b1);
    cycle(); idle(); cycle();
    check("add neg", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("add valid", 64'(out_valid), 64'd1);

    // ADDW overflow, then SRLW with oversized shift amount
    issue(ADD, 1'b1, 1'b0, 64'h7FFF_FFFF, 5'd0, 64'd1, '0, 5'd4, 1'b1);
    cycle();
    issue(SRL, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 5'd0, '0, 64'h21, 5'd5, 1'b1);
    cycle();
    check("addw", out_result, 64'hFFFF_FFFF_8000_0000);
    idle(); cycle();
    check("srlw", out_result, 64'h0000_0000_4000_0000);
    cycle();

    // Backpressure: three ADDs against a stalled memory stage
    drained.delete();
    out_ready = 1'b0;
    issue(ADD, 1'b0, 1'b1, 64'd0, 5'd0, '0, 64'd10, 5'd6, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd1, 5'd0, '0, 64'd10, 5'd6, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd2, 5'd0, '0, 64'd10, 5'd6, 1'b1);
    #1 check("bp in_ready low", 64'(in_ready), 64'd0);
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle(); idle();
    repeat (3) cycle();
    check("bp count", 64'(drained.size()), 64'd3);
    if (drained.size() == 3) begin
      check("bp r0", drained[0], 64'd10);
      check("bp r1", drained[1], 64'd11);
      check("bp r2", drained[2], 64'd12);
    end

    // Flush with both stages full and a new instruction offered
    out_ready = 1'b0;
    issue(ADD, 1'b0, 1'b1, 64'd1, 5'd0, '0, 64'd1, 5'd7, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd2, 5'd0, '0, 64'd1, 5'd7, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd3, 5'd0, '0, 64'd1, 5'd7, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0; idle();
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush s1_valid", 64'(dut.s1_valid), 64'd0);
    out_ready = 1'b1;
    drained.delete();
    repeat (3) cycle();
    check("flush no emit", 64'(drained.size()), 64'd0);

    // Back-to-back dependency x1 = 3+4; x2 = x1+1 with stale operand
`ifdef EXE_BYPASS_EN
    bypass_exp = 64'd8;
`else
    bypass_exp = 64'd1;
`endif
    issue(ADD, 1'b0, 1'b0, 64'd3, 5'd0, 64'd4, '0, 5'd1, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd0, 5'd1, '0, 64'd1, 5'd2, 1'b1); cycle();
    idle(); cycle();
    check("dep b2b", out_result, bypass_exp);
    // Same dependency with one bubble between
    issue(ADD, 1'b0, 1'b0, 64'd3, 5'd0, 64'd4, '0, 5'd1, 1'b1); cycle();
    idle(); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd0, 5'd1, '0, 64'd1, 5'd2, 1'b1); cycle();
    idle(); cycle();
    check("dep bubble", out_result, bypass_exp);

    // rd=0: writeback disabled, and index 0 never forwards
    issue(ADD, 1'b0, 1'b0, 64'd3, 5'd0, 64'd4, '0, 5'd0, 1'b1); cycle();
    issue(ADD, 1'b0, 1'b1, 64'd5, 5'd0, '0, 64'd1, 5'd8, 1'b1); cycle();
    check("x0 wen", 64'(out_wen), 64'd0);
    check("x0 result", out_result, 64'd7);
    idle(); cycle();
    check("x0 no fwd", out_result, 64'd6);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      in_word    = 1'($urandom_range(0, 1));
      if (in_word) begin
        case ($urandom_range(0, 4))
          0: in_alusel = ADD;
          1: in_alusel = SUB;
          2: in_alusel = SLL;
          3: in_alusel = SRL;
          default: in_alusel = SRA;
        endcase
      end else begin
        in_alusel = 4'($urandom_range(0, 9));
      end
      in_asel    = 1'($urandom_range(0, 1));
      in_bsel    = 1'($urandom_range(0, 1));
      in_pc      = {$urandom, $urandom};
      in_rs1_val = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 100));
      in_rs2_val = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
      in_imm     = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
      in_rs1_idx = 5'($urandom_range(0, 3));
      in_rs2_idx = 5'($urandom_range(0, 3));
      in_rd      = 5'($urandom_range(0, 3));
      in_wen     = 1'($urandom_range(0, 1));
      cycle();
    end
    flush = 1'b0; out_ready = 1'b1; idle();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
